// File: rtl/uart_word_loader.sv
// Byte-stream loader: UART command/count/data frames to 32-bit imem writes.
// Optional idle timeout inside a frame: define UART_LOADER_TIMEOUT_EN.
module uart_word_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              cpu_start,
  output logic              err_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    GET_CNT,
    DATA,
    WRITE
  } state_t;

  state_t            state;
  logic [8:0]        cnt;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       buffer;
  logic              cmd_tick;
  logic              tmo_hit;

  // load_done is high during WRITE only for the last word, so a byte
  // arriving then belongs to the command decoder, not the next word.
  assign cmd_tick  = rx_done_tick &&
                     (state == IDLE || (state == WRITE && load_done));
  assign load_busy = (state != IDLE);

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo;
  logic          waiting;

  assign waiting = (state == GET_CNT) || (state == DATA);
  assign tmo_hit = waiting && !rx_done_tick &&
                   (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || rx_done_tick || state == IDLE)
      tmo <= '0;
    else if (waiting)
      tmo <= tmo + 1'b1;
  end
`else
  // Never true; the limit only matters with the timeout built in.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      addr       <= '0;
      buffer     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
      cpu_start  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      cpu_start <= 1'b0;
      err_pulse <= 1'b0;

      unique case (state)
        IDLE: ;
        GET_CNT: begin
          if (rx_done_tick) begin
            cnt   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            idx   <= '0;
            addr  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (rx_done_tick) begin
            buffer[8*idx +: 8] <= rx_data;
            idx                <= idx + 1'b1;
            if (idx == 2'd3) begin
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= {rx_data, buffer[23:0]};
              load_done  <= (cnt == 9'd1);
            end
          end
        end
        WRITE: begin
          addr <= addr + 1'b1;
          cnt  <= cnt - 9'd1;
          if (load_done) begin
            state <= IDLE;
          end else begin
            state <= DATA;
            if (rx_done_tick) begin
              buffer[7:0] <= rx_data;
              idx         <= 2'd1;
            end
          end
        end
      endcase

      if (cmd_tick) begin
        unique case (1'b1)
          (rx_data == 8'h01): state <= GET_CNT;
          (rx_data == 8'h02): begin
            state     <= IDLE;
            cpu_start <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            err_pulse <= 1'b1;
          end
        endcase
      end

      if (tmo_hit) begin
        state     <= IDLE;
        err_pulse <= 1'b1;
        idx       <= '0;
        buffer    <= '0;
      end
    end
  end

endmodule
